// File: rtl/div_sequencer.sv
// RV32M divide-group sequencer: radix-2 restoring division, one quotient bit per cycle,
// with RISC-V sign fix-ups and the divide-by-zero / signed-overflow special results.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, done_q;

  logic              accept;
  logic              op_signed;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              b_zero, overflow;
  logic [WIDTH:0]    rem_shift, trial;
  logic [WIDTH-1:0]  rem_next, quo_next;
  logic [WIDTH-1:0]  quo_fix, rem_fix;
  logic              last_iter;

  assign accept    = (state_q == StIdle) && start && func3[2] && !flush;
  assign op_signed = ~func3[0];
  assign a_neg     = op_signed & op_a[WIDTH-1];
  assign b_neg     = op_signed & op_b[WIDTH-1];
  assign a_mag     = a_neg ? ('0 - op_a) : op_a;
  assign b_mag     = b_neg ? ('0 - op_b) : op_b;
  assign b_zero    = (op_b == '0);
  assign overflow  = op_signed && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);

  // One restoring step; trial is WIDTH+1 bits so its MSB is the borrow.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_fix   = neg_quo_q ? ('0 - quo_next) : quo_next;
  assign rem_fix   = neg_rem_q ? ('0 - rem_next) : rem_next;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_rem_d  = func3[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          if (b_zero) begin
            result_d = func3[1] ? op_a : '1;
            state_d  = StDone;
          end else if (overflow) begin
            result_d = func3[1] ? '0 : op_a;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CntW'(1);
          if (last_iter) begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        // The same instruction is still in EX here, so start is not a new request.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= (state_d == StCalc);
      done_q    <= (state_d == StDone);
    end
  end

  assign stall  = accept || (state_q == StCalc);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, random ops against a reference
// divide model, and hand-written flush / reset / non-divide sequences.
module tb_div_sequencer;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   func3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  div_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t         vecs[16];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result;
  int           checks;
  int           errors;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b100:  return sa / sb;
      3'b101:  return a / b;
      3'b110:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Drives one op starting in the current low phase; start held through DONE.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int       cyc;
    bit       seen;
    bit       bad;
    start = 1'b1;
    func3 = f3;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(exp);
    cyc  = 0;
    seen = 0;
    bad  = 0;
    while (!seen && cyc < 100) begin
      #1;
      if (done) begin
        seen = 1;
        chk({name, "_latency"}, W'(cyc), W'(lat));
        chk({name, "_stall_at_done"}, W'(stall), W'(0));
        if (exp_q.size() == 0) begin
          chk({name, "_unexpected_done"}, W'(1), W'(0));
        end else begin
          chk({name, "_result"}, result, exp_q.pop_front());
        end
      end else if (stall !== 1'b1 || busy !== (cyc != 0)) begin
        bad = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!seen) chk({name, "_timeout"}, W'(0), W'(1));
    chk({name, "_stall_busy_profile"}, W'(bad), W'(0));
    #1;
    chk({name, "_single_done"}, W'(done), W'(0));
    chk({name, "_idle_after"}, W'(busy), W'(0));
    last_result = exp;
    @(negedge clk);
    chk({name, "_result_hold"}, result, last_result);
  endtask

  initial begin
    vecs[0]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[1]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
    vecs[5]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[6]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[10] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33};
    vecs[12] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         33};
    vecs[13] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
    vecs[14] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[15] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    func3  = 3'b000;
    op_a   = '0;
    op_b   = '0;
    flush  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_result", result, '0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    for (int i = 0; i < 12; i++) begin
      logic [2:0]   f3;
      logic [W-1:0] a, b;
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      do_op($sformatf("rnd%0d", i), f3, a, b, model(f3, a, b), 33);
    end

    // Non-divide func3 and flush in IDLE must not start anything.
    start = 1'b1;
    func3 = 3'b000;
    op_a  = 32'd50;
    op_b  = 32'd5;
    #1;
    chk("nondiv_stall", W'(stall), W'(0));
    @(negedge clk);
    #1;
    chk("nondiv_busy", W'(busy), W'(0));
    chk("nondiv_done", W'(done), W'(0));
    func3 = 3'b101;
    flush = 1'b1;
    #1;
    chk("flush_idle_stall", W'(stall), W'(0));
    @(negedge clk);
    #1;
    chk("flush_idle_busy", W'(busy), W'(0));
    chk("flush_idle_done", W'(done), W'(0));
    chk("flush_idle_result", result, last_result);
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);

    // Flush at N+10: no done, result unchanged, then a new op right away.
    begin
      bit bad;
      bad   = 0;
      start = 1'b1;
      func3 = 3'b101;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (done !== 1'b0 || stall !== 1'b1) bad = 1;
        @(negedge clk);
      end
      start = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_calc_profile", W'(bad), W'(0));
      chk("flush_calc_busy", W'(busy), W'(0));
      chk("flush_calc_done", W'(done), W'(0));
      chk("flush_calc_result", result, last_result);
      do_op("after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    end

    // Synchronous reset mid-CALC aborts with no done pulse.
    begin
      int dones;
      start = 1'b1;
      func3 = 3'b101;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      repeat (6) @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_busy", W'(busy), W'(0));
      chk("rst_mid_stall", W'(stall), W'(0));
      chk("rst_mid_done", W'(done), W'(0));
      chk("rst_mid_result", result, '0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        #1;
        if (done) dones++;
      end
      chk("rst_mid_no_done", W'(dones), W'(0));
      last_result = '0;
    end

    do_op("final_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
